// File: rtl/alu_vector_sequencer_if.sv
// ALU stimulus/response bus between the self-test sequencer and the ALU.
//   alu_a, alu_b : operands to the ALU (registered by the sequencer)
//   alu_op       : op code to the ALU
//   alu_f        : ALU result
//   alu_zf       : ALU zero flag
//   alu_of       : ALU overflow flag (meaningful only for add/sub)
// master = sequencer side, slave = ALU side.
interface alu_vector_sequencer_if;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_op;
    logic [31:0] alu_f;
    logic        alu_zf;
    logic        alu_of;

    modport master (output alu_a, alu_b, alu_op, input alu_f, alu_zf, alu_of);
    modport slave  (input alu_a, alu_b, alu_op, output alu_f, alu_zf, alu_of);
endinterface

// File: rtl/alu_vector_sequencer.sv
// Self-test driver and response compactor for the 32-bit ALU.
// Walks N_VECTORS vectors; vector k uses op k[2:0], A = LFSR step 2k and
// B = LFSR step 2k+1 (A trimmed to a shift amount for op 111).  Each ALU
// response is folded into a 32-bit MISR and compared against GOLDEN_SIG.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   start       : begins a run on a rising level seen in IDLE/DONE
//   busy        : high from LOAD through the last CAPTURE
//   done, pass  : run finished / signature matched GOLDEN_SIG
//   signature   : current MISR value
//   vec_idx     : index of the vector in flight
//   alu         : operand/response bus to the ALU (master side)
module alu_vector_sequencer #(
    parameter int          N_VECTORS     = 64,
    parameter int          SETTLE_CYCLES = 2,
    parameter logic [31:0] SEED          = 32'h1ACE_B00C,
    parameter logic [31:0] GOLDEN_SIG    = 32'h0000_0000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic                          pass,
    output logic [31:0]                   signature,
    output logic [15:0]                   vec_idx,
    alu_vector_sequencer_if.master        alu
);
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SETTLE, S_CAPTURE, S_DONE
    } state_t;

    localparam logic [15:0] LAST_VEC    = 16'(N_VECTORS - 1);
    localparam logic [31:0] LAST_SETTLE = (SETTLE_CYCLES > 0) ? 32'(SETTLE_CYCLES - 1) : 32'd0;
    localparam logic [31:0] POLY        = 32'h8020_0003;

    // Galois step for x^32+x^22+x^2+x+1.
    function automatic logic [31:0] lfsr_step(input logic [31:0] l);
        return l[0] ? ((l >> 1) ^ POLY) : (l >> 1);
    endfunction

    state_t      state;
    logic [31:0] lfsr;
    logic [31:0] settle_cnt;
    logic        start_q;
    logic        launch;
    logic [31:0] lfsr_nx;
    logic [31:0] lfsr_nx2;
    logic        fb;
    logic        of_m;
    logic [31:0] misr_nx;

    // A start held high launches once; it must drop before it can launch again.
    assign launch   = start & ~start_q;
    assign lfsr_nx  = lfsr_step(lfsr);
    assign lfsr_nx2 = lfsr_step(lfsr_nx);

    // OF is only defined for add/sub, so it is masked out for every other op.
    assign fb      = signature[31] ^ signature[21] ^ signature[1] ^ signature[0];
    assign of_m    = alu.alu_of & ((alu.alu_op == 3'b100) || (alu.alu_op == 3'b101));
    assign misr_nx = {signature[30:0], fb} ^ alu.alu_f ^ {30'b0, of_m, alu.alu_zf};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            lfsr       <= SEED;
            settle_cnt <= '0;
            start_q    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            signature  <= '0;
            vec_idx    <= '0;
            alu.alu_a  <= '0;
            alu.alu_b  <= '0;
            alu.alu_op <= '0;
        end else begin
            start_q <= start;
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (launch) begin
                        state     <= S_LOAD;
                        lfsr      <= SEED;
                        signature <= '0;
                        vec_idx   <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                    end
                end
                S_LOAD: begin
                    alu.alu_op <= vec_idx[2:0];
                    // Shift op: A is the shift amount, keep only its low 5 bits.
                    alu.alu_a  <= (vec_idx[2:0] == 3'b111) ? {27'b0, lfsr[4:0]} : lfsr;
                    alu.alu_b  <= lfsr_nx;
                    settle_cnt <= '0;
                    state      <= (SETTLE_CYCLES == 0) ? S_CAPTURE : S_SETTLE;
                end
                S_SETTLE: begin
                    settle_cnt <= settle_cnt + 32'd1;
                    if (settle_cnt == LAST_SETTLE) state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    signature <= misr_nx;
                    lfsr      <= lfsr_nx2;
                    if (vec_idx == LAST_VEC) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (misr_nx == GOLDEN_SIG);
                    end else begin
                        vec_idx <= vec_idx + 16'd1;
                        state   <= S_LOAD;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
